// File: rtl/riscv_regfile_sb.sv
// Integer register file x0..x31 with a per-register busy scoreboard.
// Issue side checks RAW/WAW hazards and launches registered operands; writeback side updates data and clears busy.
module riscv_regfile_sb #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_VALUE = '0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            issue_vld,
   input  logic [4:0]      issue_rs1,
   input  logic [4:0]      issue_rs2,
   input  logic [4:0]      issue_rd,
   input  logic            issue_rd_en,
   output logic            issue_rdy,
   output logic            exu_vld,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic            register_write_en,
   input  logic [4:0]      register_write,
   input  logic [XLEN-1:0] register_write_data,
   input  logic            flush,
   output logic [31:0]     busy
);

   logic [XLEN-1:0] regs_reg [0:31];
   logic [31:0]     busy_reg, busy_next;
   logic            exu_vld_reg;
   logic [XLEN-1:0] rs1_data_reg, rs2_data_reg;

   logic [31:0]     wr_mask, set_mask, eff_busy;
   logic            accept;
   logic [XLEN-1:0] rs1_val, rs2_val;

   assign wr_mask  = {31'b0, register_write_en} << register_write;
   assign eff_busy = busy_reg & ~wr_mask;

   assign issue_rdy = ~flush & ~reset & ~eff_busy[issue_rs1] & ~eff_busy[issue_rs2]
                    & ~(issue_rd_en & eff_busy[issue_rd]);
   assign accept    = issue_vld & issue_rdy;
   assign set_mask  = {31'b0, accept & issue_rd_en & (issue_rd != 5'd0)} << issue_rd;

   // Operand read with same-cycle writeback bypass; x0 is hardwired to zero.
   always_comb begin
      rs1_val = regs_reg[issue_rs1];
      rs2_val = regs_reg[issue_rs2];
      if (register_write_en && register_write == issue_rs1) rs1_val = register_write_data;
      if (register_write_en && register_write == issue_rs2) rs2_val = register_write_data;
      if (issue_rs1 == 5'd0) rs1_val = '0;
      if (issue_rs2 == 5'd0) rs2_val = '0;
   end

   // Set wins over a simultaneous clear of the same rd.
   always_comb begin
      busy_next = (busy_reg & ~wr_mask) | set_mask;
      if (flush) busy_next = '0;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      regs_reg[0] <= '0;
      for (int i = 1; i < 32; i++) begin
         if (reset)
            regs_reg[i] <= RESET_VALUE;
         else if (register_write_en && register_write == 5'(i))
            regs_reg[i] <= register_write_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy_reg     <= '0;
         exu_vld_reg  <= 1'b0;
         rs1_data_reg <= '0;
         rs2_data_reg <= '0;
      end else begin
         busy_reg    <= busy_next;
         exu_vld_reg <= accept;
         if (accept) begin
            rs1_data_reg <= rs1_val;
            rs2_data_reg <= rs2_val;
         end
      end
   end

   assign busy     = busy_reg;
   assign exu_vld  = exu_vld_reg;
   assign rs1_data = rs1_data_reg;
   assign rs2_data = rs2_data_reg;

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Self-checking bench for riscv_regfile_sb: directed scenarios followed by random traffic
// compared against an array/bitmask model of register file and scoreboard.
module tb_riscv_regfile_sb;
   localparam int          XLEN        = 32;
   localparam logic [31:0] RESET_VALUE = 32'h0;

   logic        clock = 1'b0;
   logic        reset;
   logic        issue_vld, issue_rd_en, issue_rdy, exu_vld;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd, register_write;
   logic        register_write_en, flush;
   logic [31:0] register_write_data, rs1_data, rs2_data, busy;

   riscv_regfile_sb #(.XLEN(XLEN), .RESET_VALUE(RESET_VALUE)) dut (
      .clock(clock), .reset(reset),
      .issue_vld(issue_vld), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_rd(issue_rd), .issue_rd_en(issue_rd_en), .issue_rdy(issue_rdy),
      .exu_vld(exu_vld), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .register_write_en(register_write_en), .register_write(register_write),
      .register_write_data(register_write_data), .flush(flush), .busy(busy)
   );

   always #5 clock = ~clock;

   // Reference model
   logic [31:0] m_mem [32];
   bit          m_busy [32];
   logic        m_vld;
   logic [31:0] m_rs1, m_rs2;

   int n_checks = 0;
   int n_errors = 0;
   int n_cycle  = 0;
   logic last_rdy;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, observed, expected, n_cycle);
      end
   endtask

   task automatic drive(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic rd_en, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic fl, input logic rst);
      issue_vld = vld; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_rd_en = rd_en;
      register_write_en = we; register_write = wa; register_write_data = wd;
      flush = fl; reset = rst;
   endtask

   function automatic bit pending(input logic [4:0] r);
      return m_busy[r] && !(register_write_en && register_write == r);
   endfunction

   function automatic logic model_rdy();
      return !flush && !reset && !pending(issue_rs1) && !pending(issue_rs2)
             && !(issue_rd_en && pending(issue_rd));
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] r);
      if (r == 0) return 32'h0;
      if (register_write_en && register_write == r) return register_write_data;
      return m_mem[r];
   endfunction

   function automatic logic [31:0] model_busy_word();
      logic [31:0] w = '0;
      for (int i = 0; i < 32; i++) w[i] = m_busy[i];
      return w;
   endfunction

   task automatic model_update(input logic rdy);
      logic acc;
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            m_mem[i]  = (i == 0) ? 32'h0 : RESET_VALUE;
            m_busy[i] = 0;
         end
         m_vld = 0; m_rs1 = 0; m_rs2 = 0;
         return;
      end
      acc = issue_vld && rdy;
      if (acc) begin
         m_rs1 = model_read(issue_rs1);
         m_rs2 = model_read(issue_rs2);
      end
      m_vld = acc;
      if (register_write_en && register_write != 0) m_mem[register_write] = register_write_data;
      if (flush) begin
         for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else begin
         if (register_write_en) m_busy[register_write] = 0;
         if (acc && issue_rd_en && issue_rd != 0) m_busy[issue_rd] = 1;
      end
   endtask

   task automatic cycle();
      logic exp_rdy;
      @(negedge clock);
      exp_rdy  = model_rdy();
      last_rdy = issue_rdy;
      check("issue_rdy", {31'b0, issue_rdy}, {31'b0, exp_rdy});
      model_update(exp_rdy);
      @(posedge clock);
      #1;
      n_cycle++;
      check("exu_vld", {31'b0, exu_vld}, {31'b0, m_vld});
      check("rs1_data", rs1_data, m_rs1);
      check("rs2_data", rs2_data, m_rs2);
      check("busy", busy, model_busy_word());
      $display("cyc %0d: rst=%0b fl=%0b iss=%0b rs1=%0d rs2=%0d rd=%0d/%0b rdy=%0b wb=%0b x%0d=%08h -> vld=%0b d1=%08h d2=%08h busy=%08h",
               n_cycle, reset, flush, issue_vld, issue_rs1, issue_rs2, issue_rd, issue_rd_en, last_rdy,
               register_write_en, register_write, register_write_data, exu_vld, rs1_data, rs2_data, busy);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = 0; m_busy[i] = 0; end
      m_vld = 0; m_rs1 = 0; m_rs2 = 0;

      // Reset state
      drive(0, 0, 0, 0, 0, 1, 5'd4, 32'hAAAA, 0, 1);
      cycle();
      cycle();
      check("reset_busy", busy, 32'h0);
      check("reset_vld", {31'b0, exu_vld}, 32'h0);

      // Basic issue
      drive(1, 1, 2, 3, 1, 0, 0, 0, 0, 0);
      cycle();
      check("t1_rdy", {31'b0, last_rdy}, 32'h1);
      check("t1_vld", {31'b0, exu_vld}, 32'h1);
      check("t1_rs1", rs1_data, 32'h0);
      check("t1_busy", busy, 32'h8);

      // RAW stall resolved by same-cycle writeback bypass
      drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      check("t2_stall", {31'b0, last_rdy}, 32'h0);
      check("t2_novld", {31'b0, exu_vld}, 32'h0);
      drive(1, 3, 0, 0, 0, 1, 3, 32'hDEADBEEF, 0, 0);
      cycle();
      check("t2_rdy", {31'b0, last_rdy}, 32'h1);
      check("t2_rs1", rs1_data, 32'hDEADBEEF);
      check("t2_busy", busy, 32'h0);

      // x0 behaviour
      drive(0, 0, 0, 0, 0, 1, 0, 32'h1234, 0, 0);
      cycle();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      check("t3_rs1", rs1_data, 32'h0);
      drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      cycle();
      check("t3_busy", busy, 32'h0);

      // Simultaneous clear and set of the same rd
      drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
      cycle();
      check("t4_busy_a", busy, 32'h20);
      drive(1, 0, 0, 5, 1, 1, 5, 32'h55, 0, 0);
      cycle();
      check("t4_rdy", {31'b0, last_rdy}, 32'h1);
      check("t4_busy_b", busy, 32'h20);
      drive(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      check("t4_stall", {31'b0, last_rdy}, 32'h0);
      drive(1, 5, 0, 0, 0, 1, 5, 32'h66, 0, 0);
      cycle();
      check("t4_rs1", rs1_data, 32'h66);

      // Flush
      drive(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
      cycle();
      drive(1, 0, 0, 8, 1, 0, 0, 0, 0, 0);
      cycle();
      check("t5_busy_a", busy, 32'h180);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cycle();
      check("t5_rdy", {31'b0, last_rdy}, 32'h0);
      check("t5_busy_b", busy, 32'h0);
      check("t5_vld", {31'b0, exu_vld}, 32'h0);
      drive(0, 0, 0, 0, 0, 1, 7, 32'h77, 0, 0);
      cycle();
      drive(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      check("t5_rs1", rs1_data, 32'h77);

      // Reset mid-operation
      drive(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
      cycle();
      drive(1, 0, 0, 8, 1, 0, 0, 0, 0, 0);
      cycle();
      drive(0, 0, 0, 0, 0, 1, 9, 32'h99, 0, 1);
      cycle();
      check("t6_busy", busy, 32'h0);
      check("t6_vld", {31'b0, exu_vld}, 32'h0);
      drive(1, 9, 7, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      check("t6_rs1", rs1_data, RESET_VALUE);

      // Random traffic over a small register window to provoke hazards
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 7)), $urandom(), $urandom_range(0, 29) == 0,
               $urandom_range(0, 99) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
